// File: rtl/multi_tick_gen.sv
// -----------------------------------------------------------------------------
// multi_tick_gen
//
// Multi-channel programmable tick generator. Each channel divides clk by its
// own runtime-loadable divisor and produces a one-cycle tick pulse at every
// terminal count. A channel runs free (periodic) or produces exactly one tick
// per start pulse (one-shot). A square output toggles on every tick.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   en        in   [CH]     per-channel level enable
//   start     in   [CH]     per-channel one-shot trigger (single-cycle pulse)
//   cfg_we    in   configuration write strobe
//   cfg_ch    in   [CW]     channel index for the configuration write
//   cfg_div   in   [WIDTH]  divisor to load
//   cfg_mode  in   0 = periodic, 1 = one-shot
//   tick      out  [CH]     registered one-cycle pulse per terminal count
//   busy      out  [CH]     registered; channel is counting
//   square    out  [CH]     registered; toggles on every tick
// -----------------------------------------------------------------------------
module multi_tick_gen #(
    parameter int CH          = 4,
    parameter int WIDTH       = 18,
    parameter int DEFAULT_DIV = 131072,
    localparam int CW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    en,
    input  logic [CH-1:0]    start,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    square
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    // One bit wider than cfg_ch so that an index of CH or above is detectable
    // even when CH is a power of two.
    localparam logic [CW:0] CH_LIM = (CW+1)'(CH);

    logic [WIDTH-1:0] div_q [CH];
    logic [WIDTH-1:0] div_d [CH];
    logic [WIDTH-1:0] cnt_q [CH];
    logic [WIDTH-1:0] cnt_d [CH];
    logic [CH-1:0]    mode_q, mode_d;
    logic [CH-1:0]    armed_q, armed_d;
    logic [CH-1:0]    tick_q, tick_d;
    logic [CH-1:0]    busy_q, busy_d;
    logic [CH-1:0]    square_q, square_d;

    logic             cfg_valid_s;
    logic [CH-1:0]    wr_s;
    logic [CH-1:0]    active_s;
    logic [CH-1:0]    term_s;

    // Next-state computation for every channel: config write, counting, arming.
    always_comb begin
        cfg_valid_s = cfg_we && ({1'b0, cfg_ch} < CH_LIM);
        for (int i = 0; i < CH; i++) begin
            wr_s[i]     = cfg_valid_s && (cfg_ch == CW'(i));
            active_s[i] = en[i] && (div_q[i] != CNT_ZERO) && (!mode_q[i] || armed_q[i]);
            term_s[i]   = (cnt_q[i] == (div_q[i] - CNT_ONE));

            div_d[i]    = div_q[i];
            mode_d[i]   = mode_q[i];
            cnt_d[i]    = CNT_ZERO;
            armed_d[i]  = armed_q[i];
            tick_d[i]   = 1'b0;
            square_d[i] = square_q[i];

            if (wr_s[i]) begin
                // A write wins over a coincident terminal count and drops any
                // start pulse in the same cycle.
                div_d[i]    = cfg_div;
                mode_d[i]   = cfg_mode;
                cnt_d[i]    = CNT_ZERO;
                armed_d[i]  = 1'b0;
                tick_d[i]   = 1'b0;
                square_d[i] = 1'b0;
            end else begin
                if (active_s[i]) begin
                    if (term_s[i]) begin
                        cnt_d[i]    = CNT_ZERO;
                        tick_d[i]   = 1'b1;
                        square_d[i] = ~square_q[i];
                    end else begin
                        cnt_d[i]    = cnt_q[i] + CNT_ONE;
                        tick_d[i]   = 1'b0;
                    end
                end else begin
                    cnt_d[i]  = CNT_ZERO;
                    tick_d[i] = 1'b0;
                end

                if (!en[i]) begin
                    armed_d[i] = 1'b0;
                end else if (mode_q[i] && active_s[i] && term_s[i]) begin
                    // The single one-shot tick disarms the channel.
                    armed_d[i] = 1'b0;
                end else if (mode_q[i] && !armed_q[i] && start[i]) begin
                    armed_d[i] = 1'b1;
                end else begin
                    armed_d[i] = armed_q[i];
                end
            end

            // busy reflects whether the channel will be counting in the next
            // cycle, so it rises together with the arming start pulse.
            busy_d[i] = en[i] && (div_d[i] != CNT_ZERO) && (!mode_d[i] || armed_d[i]);
        end
    end

    // Channel state registers with asynchronous reset to the defaults.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                div_q[i] <= DIV_RST;
                cnt_q[i] <= CNT_ZERO;
            end
            mode_q   <= {CH{1'b0}};
            armed_q  <= {CH{1'b0}};
            tick_q   <= {CH{1'b0}};
            busy_q   <= {CH{1'b0}};
            square_q <= {CH{1'b0}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            mode_q   <= mode_d;
            armed_q  <= armed_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
            square_q <= square_d;
        end
    end

    assign tick   = tick_q;
    assign busy   = busy_q;
    assign square = square_q;

endmodule

// File: tb/tb_multi_tick_gen.sv
module tb_multi_tick_gen;

    localparam int CH    = 5;
    localparam int WIDTH = 18;
    localparam int DDIV  = 20;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [CH-1:0]    en;
    logic [CH-1:0]    start;
    logic             cfg_we;
    logic [CW-1:0]    cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_mode;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    square;

    multi_tick_gen #(.CH(CH), .WIDTH(WIDTH), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .tick(tick), .busy(busy), .square(square)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string name;
        int    ch;
        logic  tk;
        logic  bz;
        logic  sq;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string name;
        int    ch;
        int    div;
        int    cycles;
        int    exp_ticks;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic push(input string name, input int ch, input logic tk, input logic bz, input logic sq);
        exp_t e;
        e.name = name; e.ch = ch; e.tk = tk; e.bz = bz; e.sq = sq;
        sb_q.push_back(e);
    endtask

    // Advance one edge, then compare every pending expectation ({tick,busy,square}).
    task automatic step();
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("%s ch%0d t=%0t", e.name, e.ch, $time),
                  {29'd0, tick[e.ch], busy[e.ch], square[e.ch]},
                  {29'd0, e.tk, e.bz, e.sq});
        end
    endtask

    task automatic cfg(input int ch, input int div, input logic mode);
        cfg_we   = 1'b1;
        cfg_ch   = CW'(ch);
        cfg_div  = WIDTH'(div);
        cfg_mode = mode;
        step();
        cfg_we   = 1'b0;
    endtask

    // Periodic run from an en rising edge: tick after edge k when k%d == d-1.
    task automatic run_periodic(input int ch, input int d, input int n, input string name, output int obs);
        logic sq;
        logic tk;
        sq  = 1'b0;
        obs = 0;
        en[ch] = 1'b1;
        for (int k = 0; k < n; k++) begin
            tk = (d != 0) && ((k % d) == (d - 1));
            if (tk) sq = ~sq;
            push(name, ch, tk, (d != 0), sq);
            step();
            if (tick[ch]) obs++;
        end
        en[ch] = 1'b0;
        push({name, "_off"}, ch, 1'b0, 1'b0, sq);
        step();
    endtask

    initial begin
        int   obs;
        logic sq;
        logic tk;

        tbl[0] = '{name: "div5", ch: 1, div: 5, cycles: 21, exp_ticks: 4};
        tbl[1] = '{name: "div1", ch: 1, div: 1, cycles: 5,  exp_ticks: 5};
        tbl[2] = '{name: "div0", ch: 1, div: 0, cycles: 5,  exp_ticks: 0};
        tbl[3] = '{name: "div7", ch: 4, div: 7, cycles: 15, exp_ticks: 2};
        tbl[4] = '{name: "div2", ch: 2, div: 2, cycles: 6,  exp_ticks: 3};

        reset = 1'b1; en = '0; start = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {17'd0, tick, busy, square}, 32'd0);
        reset = 1'b0;

        // Reset default divisor on ch0.
        run_periodic(0, DDIV, 42, "default", obs);
        check("default_count", obs, 32'd2);

        // Periodic table.
        for (int v = 0; v < 5; v++) begin
            cfg(tbl[v].ch, tbl[v].div, 1'b0);
            run_periodic(tbl[v].ch, tbl[v].div, tbl[v].cycles, tbl[v].name, obs);
            check({tbl[v].name, "_count"}, obs, tbl[v].exp_ticks);
        end

        // One-shot on ch2, div 3.
        cfg(2, 3, 1'b1);
        en[2] = 1'b1;
        push("os_idle", 2, 1'b0, 1'b0, 1'b0); step();
        start[2] = 1'b1;
        push("os_e0", 2, 1'b0, 1'b1, 1'b0); step();
        push("os_e1_restart", 2, 1'b0, 1'b1, 1'b0); step();
        start[2] = 1'b0;
        push("os_e2", 2, 1'b0, 1'b1, 1'b0); step();
        push("os_e3", 2, 1'b1, 1'b0, 1'b1); step();
        push("os_e4", 2, 1'b0, 1'b0, 1'b1); step();
        start[2] = 1'b1;
        push("os2_e0", 2, 1'b0, 1'b1, 1'b1); step();
        start[2] = 1'b0;
        push("os2_e1", 2, 1'b0, 1'b1, 1'b1); step();
        push("os2_e2", 2, 1'b0, 1'b1, 1'b1); step();
        push("os2_e3", 2, 1'b1, 1'b0, 1'b0); step();
        push("os2_e4", 2, 1'b0, 1'b0, 1'b0); step();
        // start with en low is ignored.
        en[2] = 1'b0; start[2] = 1'b1;
        push("os_noen", 2, 1'b0, 1'b0, 1'b0); step();
        start[2] = 1'b0; en[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push("os_noen_after", 2, 1'b0, 1'b0, 1'b0); step();
        end
        // start coincident with a config write is dropped.
        start[2] = 1'b1;
        push("os_wr_start", 2, 1'b0, 1'b0, 1'b0);
        cfg(2, 3, 1'b1);
        start[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push("os_wr_after", 2, 1'b0, 1'b0, 1'b0); step();
        end
        en[2] = 1'b0;

        // ch3: reprogram mid-count, invalid indices, write at terminal count, en drop.
        cfg(3, 10, 1'b0);
        sq = 1'b0;
        for (int e = 0; e < 47; e++) begin
            en[3]  = !(e == 40 || e == 41);
            cfg_we = 1'b0;
            if (e == 17 || e == 33) begin
                cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 18'd4; cfg_mode = 1'b0;
            end else if (e == 27) begin
                cfg_we = 1'b1; cfg_ch = 3'd5; cfg_div = 18'd1; cfg_mode = 1'b0;
            end else if (e == 30) begin
                cfg_we = 1'b1; cfg_ch = 3'd7; cfg_div = 18'd1; cfg_mode = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            tk = (e == 9 || e == 21 || e == 25 || e == 29 || e == 37 || e == 45);
            if (e == 17 || e == 33) sq = 1'b0;
            else if (tk) sq = ~sq;
            push($sformatf("seq3_e%0d", e), 3, tk, en[3], sq);
            step();
        end
        cfg_we = 1'b0;
        en[3]  = 1'b0;
        push("seq3_off", 3, 1'b0, 1'b0, sq); step();

        // Async reset mid-count; divisors revert to the default.
        cfg(4, 7, 1'b0);
        en[0] = 1'b1; en[3] = 1'b1; en[4] = 1'b1;
        repeat (8) step();
        check("pre_reset_ch4", {30'd0, busy[4], square[4]}, 32'd3);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {17'd0, tick, busy, square}, 32'd0);
        en = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_periodic(4, DDIV, 21, "revert", obs);
        check("revert_count", obs, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_tick_gen.md
# multi_tick_gen

Parametrised, multi-channel programmable tick generator. Each channel divides `clk` by a runtime-loadable divisor and emits one-cycle `tick` pulses, either free-running (periodic) or once per `start` (one-shot), plus a toggling `square` output. It replaces fixed power-of-two dividers wherever FND scan, key debounce, motor step or door timers need their own rate from one shared clock.

## Interface
Parameters:
- `CH`, 4, number of independent channels (1..16)
- `WIDTH`, 18, divisor/counter width in bits
- `DEFAULT_DIV`, 131072, divisor loaded into every channel at reset (must fit in `WIDTH`)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `en`  in  CH  per-channel enable, level
- `start`  in  CH  per-channel one-shot trigger, one-cycle pulse
- `cfg_we`  in  1  configuration write strobe
- `cfg_ch`  in  $clog2(CH) (min 1)  channel index for write
- `cfg_div`  in  WIDTH  divisor to load
- `cfg_mode`  in  1  0 = periodic, 1 = one-shot
- `tick`  out  CH  registered one-cycle pulse per terminal count
- `busy`  out  CH  registered; channel currently counting
- `square`  out  CH  registered; toggles on every tick

## Operation
- Per channel: `div` (WIDTH), `mode` (1), `cnt` (WIDTH) and `armed` (1, one-shot only).
- Reset: every `div`=DEFAULT_DIV, `mode`=0, `cnt`=0, `armed`=0; all of `tick`, `busy`, `square`=0.
- Active condition: periodic → `en[i]` && `div`≠0; one-shot → `en[i]` && `armed` && `div`≠0.
- Active cycle: if `cnt`==`div`−1 then `cnt`←0 and `tick`←1, else `cnt`←`cnt`+1 and `tick`←0.
- Inactive cycle: `cnt`←0, `tick`←0; `square` holds its value.
- `div`=0: channel never ticks, `busy`=0. `div`=1: tick every cycle while active.
- One-shot: `start[i]` with `en[i]`=1 and `armed`=0 sets `armed`. On the terminal-count tick, `armed` is cleared, so exactly one tick is produced. `start` while armed is ignored. `start` with `en`=0 is ignored.
- `en[i]` falling clears `armed`. The channel restarts from `cnt`=0.
- `busy[i]` equals the active condition, registered.
- `square[i]` ← ~`square[i]` on each cycle that `tick[i]`←1. In periodic mode, period 2·div and 50 % duty.
- Config write (`cfg_we`=1, `cfg_ch`<CH) loads `div`/`mode` and clears that channel's `cnt`, `armed`, `tick` and `square`. A write with `cfg_ch`≥CH is ignored entirely.
- Simultaneous events:
  - Config write has priority over a terminal count in the same cycle; no tick is produced.
  - `start` coincident with a config write is dropped.
  - Channels are fully independent; a write to one never disturbs the others.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Periodic, divisor D, `en` rising sampled at edge 0: `tick` is high in the cycle after edge D−1, then every D cycles.
- One-shot: `start` sampled at edge 0 → `busy` high after edge 0 → single `tick` after edge D. `busy` low and `tick` low after edge D+1.
- Config write sampled at edge k: the new divisor governs counting from edge k+1. The first tick comes D cycles later.
- Reset asserted mid-count clears everything immediately (async). The first edge after release behaves as an `en` rising edge.

## Test plan
- Reset defaults: `en`=1 on ch0, no config → first `tick[0]` after 131072 cycles, `square[0]`=1. Check all outputs are 0 during reset.
- Periodic divisor: write ch1 div=5, mode=0, `en[1]`=1 → ticks exactly every 5 cycles, `square[1]` period 10. Repeat with div=1 (tick every cycle) and div=0 (no tick, `busy`=0).
- One-shot: write ch2 div=3, mode=1, then pulse `start[2]` → `busy` for 3 cycles and one `tick`. A second `start` while busy is ignored, and a `start` after completion gives another tick.
- Mid-count reprogram: ch3 div=10 counting at cnt=7, write div=4 → no tick at the old terminal count; next tick 4 cycles after the write, `square[3]` cleared.
- Boundaries:
  - A write with `cfg_ch`=CH changes nothing.
  - A write coincident with a terminal count suppresses the tick.
  - Dropping `en` mid-count then re-enabling restarts the full period.
- Async reset asserted mid-count on all channels → outputs 0 within the same cycle. Divisors revert to DEFAULT_DIV.
